// File: rtl/fg_cfg_pkg.sv
// Shared constants for the function-generator configuration loader: opcodes,
// FSM state encoding, frame lengths and the default configuration word width.
package fg_cfg_pkg;

    localparam int CONFIG_REG_BITWIDTH_DEFAULT = 64;
    localparam int FRAME_LEN_SHORT             = 8;
    localparam int FRAME_LEN_LONG              = FRAME_LEN_SHORT + CONFIG_REG_BITWIDTH_DEFAULT;

    typedef logic [7:0] opcode_t;

    localparam opcode_t OP_WRITE   = 8'hA1;
    localparam opcode_t OP_STAGE   = 8'hA2;
    localparam opcode_t OP_COMMIT  = 8'hA3;
    localparam opcode_t OP_DISABLE = 8'hB0;
    localparam opcode_t OP_ENABLE  = 8'hB1;
    localparam opcode_t OP_READ    = 8'hC0;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE     = 2'd0;
    localparam fsm_state_t ST_OPCODE   = 2'd1;
    localparam fsm_state_t ST_PAYLOAD  = 2'd2;
    localparam fsm_state_t ST_WAIT_END = 2'd3;

    function automatic logic op_has_payload(input opcode_t op, input logic readback_en);
        return (op == OP_WRITE) || (op == OP_STAGE) || (readback_en && (op == OP_READ));
    endfunction

    function automatic logic op_is_short(input opcode_t op);
        return (op == OP_COMMIT) || (op == OP_DISABLE) || (op == OP_ENABLE);
    endfunction

endpackage

// File: rtl/fg_sync_edge.sv
// N-stage synchronizer for an asynchronous input with rise/fall pulses
// derived from the synchronized level.
module fg_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_reg <= {STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d_i};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level_o = sync_reg[STAGES-1];
    assign rise_o  = sync_reg[STAGES-1] & ~prev_reg;
    assign fall_o  = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/fg_config_loader.sv
// SPI (mode 0) configuration loader: shadow/active config word with atomic commit.
// Optional read-back opcode 0xC0 is built when FG_CFG_READBACK_EN is defined.
module fg_config_loader
    import fg_cfg_pkg::*;
#(
    parameter int CONFIG_REG_BITWIDTH = CONFIG_REG_BITWIDTH_DEFAULT,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           sclk_i,
    input  logic                           cs_n_i,
    input  logic                           mosi_i,
    output logic                           miso_o,
    output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
    output logic                           outputEnable_o,
    output logic                           configUpdate_o,
    output logic                           frameError_o
);

`ifdef FG_CFG_READBACK_EN
    localparam logic READBACK_EN = 1'b1;
`else
    localparam logic READBACK_EN = 1'b0;
`endif

    localparam int CNT_W    = $clog2(FRAME_LEN_SHORT + CONFIG_REG_BITWIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_SHORT   = CNT_W'(FRAME_LEN_SHORT);
    localparam logic [CNT_W-1:0] CNT_LONG    = CNT_W'(FRAME_LEN_SHORT + CONFIG_REG_BITWIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST_OP = CNT_W'(FRAME_LEN_SHORT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_PL = CNT_W'(FRAME_LEN_SHORT + CONFIG_REG_BITWIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic mosi_sync;

    fg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i(clk_i), .rstn_i(rstn_i), .d_i(sclk_i),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    // cs_n idles high, so its synchronizer resets high to avoid a false frame start.
    fg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i(clk_i), .rstn_i(rstn_i), .d_i(cs_n_i),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) mosi_sync_reg <= '0;
        else         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi_i};
    end
    assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];

    fsm_state_t                     state_reg;
    opcode_t                        opcode_reg;
    logic [CNT_W-1:0]               cnt_reg;
    logic [CONFIG_REG_BITWIDTH-1:0] shadow_reg;
    logic [CONFIG_REG_BITWIDTH-1:0] active_reg;
    logic                           oe_reg;
    logic                           update_reg;
    logic                           error_reg;
    opcode_t                        opcode_next;
    logic                           frame_ok;

    assign opcode_next = {opcode_reg[6:0], mosi_sync};
    assign frame_ok    = ((cnt_reg == CNT_SHORT) && op_is_short(opcode_reg)) ||
                         ((cnt_reg == CNT_LONG)  && op_has_payload(opcode_reg, READBACK_EN));

    // cs_n rising has priority over a coincident sclk edge: the frame closes first.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg  <= ST_IDLE;
            opcode_reg <= '0;
            cnt_reg    <= '0;
            shadow_reg <= '0;
            active_reg <= '0;
            oe_reg     <= 1'b0;
            update_reg <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            update_reg <= 1'b0;
            if (cs_rise) begin
                state_reg <= ST_IDLE;
                if (state_reg != ST_IDLE) begin
                    if (frame_ok) begin
                        error_reg <= 1'b0;
                        case (opcode_reg)
                            OP_WRITE, OP_COMMIT: begin
                                active_reg <= shadow_reg;
                                update_reg <= 1'b1;
                            end
                            OP_ENABLE:  oe_reg <= 1'b1;
                            OP_DISABLE: oe_reg <= 1'b0;
                            default: ;
                        endcase
                    end else begin
                        error_reg <= 1'b1;
                    end
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_reg  <= ST_OPCODE;
                            cnt_reg    <= '0;
                            opcode_reg <= '0;
                        end
                    end
                    ST_OPCODE: begin
                        if (sclk_rise) begin
                            opcode_reg <= opcode_next;
                            cnt_reg    <= cnt_reg + CNT_W'(1);
                            if (cnt_reg == CNT_LAST_OP)
                                state_reg <= op_has_payload(opcode_next, READBACK_EN) ? ST_PAYLOAD : ST_WAIT_END;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (sclk_rise) begin
                            if ((opcode_reg == OP_WRITE) || (opcode_reg == OP_STAGE))
                                shadow_reg <= {shadow_reg[CONFIG_REG_BITWIDTH-2:0], mosi_sync};
                            cnt_reg <= cnt_reg + CNT_W'(1);
                            if (cnt_reg == CNT_LAST_PL)
                                state_reg <= ST_WAIT_END;
                        end
                    end
                    default: begin
                        // Extra clocks push the count past a valid length; saturate so it never wraps back.
                        if (sclk_rise && (cnt_reg != CNT_MAX))
                            cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                endcase
            end
        end
    end

`ifdef FG_CFG_READBACK_EN
    logic [CONFIG_REG_BITWIDTH-1:0] rb_reg;
    logic                           miso_reg;

    // MSB is presented on the falling edge after the opcode so it is valid for the first payload rise.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rb_reg   <= '0;
            miso_reg <= 1'b0;
        end else if (cs_rise) begin
            miso_reg <= 1'b0;
        end else if ((state_reg == ST_OPCODE) && sclk_rise && (cnt_reg == CNT_LAST_OP) &&
                     (opcode_next == OP_READ)) begin
            rb_reg <= active_reg;
        end else if ((state_reg == ST_PAYLOAD) && (opcode_reg == OP_READ)) begin
            if (sclk_fall) {miso_reg, rb_reg} <= {rb_reg, 1'b0};
        end else begin
            miso_reg <= 1'b0;
        end
    end
    assign miso_o = miso_reg;
`else
    assign miso_o = 1'b0;
`endif

    logic sync_unused;
    assign sync_unused = &{1'b0, sclk_level, sclk_fall, cs_level};

    assign CR_bus_o       = active_reg;
    assign outputEnable_o = oe_reg;
    assign configUpdate_o = update_reg;
    assign frameError_o   = error_reg;

endmodule

// File: tb/tb_fg_config_loader.sv
// Directed bench for fg_config_loader: SPI frames bit-banged from clk_i, checks
// commit latency, frame validation, read-back (FG_CFG_READBACK_EN) and reset.
module tb_fg_config_loader;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        sclk_i = 1'b0;
    logic        cs_n_i = 1'b1;
    logic        mosi_i = 1'b0;
    logic        miso_o;
    logic [63:0] CR_bus_o;
    logic        outputEnable_o;
    logic        configUpdate_o;
    logic        frameError_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] cap;

    always #5 clk_i = ~clk_i;

    fg_config_loader #(.CONFIG_REG_BITWIDTH(64), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .sclk_i(sclk_i), .cs_n_i(cs_n_i),
        .mosi_i(mosi_i), .miso_o(miso_o), .CR_bus_o(CR_bus_o),
        .outputEnable_o(outputEnable_o), .configUpdate_o(configUpdate_o),
        .frameError_o(frameError_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-20s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drives cs_n low and clocks nbits bits (opcode then payload), leaving cs_n low.
    task automatic frame_body(input logic [7:0] op, input logic [63:0] data, input int nbits,
                              output logic [63:0] miso_cap);
        logic b;
        miso_cap = '0;
        @(negedge clk_i) cs_n_i = 1'b0;
        repeat (HALF) @(negedge clk_i);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8)       b = op[7-i];
            else if (i < 72) b = data[71-i];
            else             b = 1'b0;
            mosi_i = b;
            repeat (HALF) @(negedge clk_i);
            if (i >= 8 && i < 72) miso_cap[71-i] = miso_o;
            sclk_i = 1'b1;
            repeat (HALF) @(negedge clk_i);
            sclk_i = 1'b0;
        end
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic end_frame();
        @(negedge clk_i) cs_n_i = 1'b1;
        repeat (SYNC_STAGES + 4) @(posedge clk_i);
        #1;
    endtask

    // Raises cs_n and checks the committed word appears exactly SYNC_STAGES+1 cycles later.
    task automatic end_frame_commit(input string tag, input logic [63:0] old_v, input logic [63:0] new_v);
        @(negedge clk_i) cs_n_i = 1'b1;
        repeat (SYNC_STAGES) @(posedge clk_i);
        #1;
        chk({tag, "_cr_early"}, CR_bus_o, old_v);
        chk({tag, "_upd_early"}, {63'd0, configUpdate_o}, 64'd0);
        @(posedge clk_i);
        #1;
        chk({tag, "_cr"}, CR_bus_o, new_v);
        chk({tag, "_upd"}, {63'd0, configUpdate_o}, 64'd1);
        @(posedge clk_i);
        #1;
        chk({tag, "_upd_once"}, {63'd0, configUpdate_o}, 64'd0);
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge clk_i);
        #1;
        chk("rst_cr", CR_bus_o, 64'd0);
        chk("rst_oe", {63'd0, outputEnable_o}, 64'd0);
        chk("rst_upd", {63'd0, configUpdate_o}, 64'd0);
        chk("rst_err", {63'd0, frameError_o}, 64'd0);
        chk("rst_miso", {63'd0, miso_o}, 64'd0);
        @(negedge clk_i) rstn_i = 1'b1;
        repeat (5) @(posedge clk_i);

        frame_body(8'hA1, 64'h8000_0000_0000_0011, 72, cap);
        end_frame_commit("write", 64'd0, 64'h8000_0000_0000_0011);
        chk("write_err", {63'd0, frameError_o}, 64'd0);

        frame_body(8'hA2, 64'h0123_4567_89AB_CDEF, 72, cap);
        end_frame();
        chk("stage_cr", CR_bus_o, 64'h8000_0000_0000_0011);

        frame_body(8'hA3, 64'd0, 8, cap);
        end_frame_commit("commit", 64'h8000_0000_0000_0011, 64'h0123_4567_89AB_CDEF);

        frame_body(8'hA1, 64'hDEAD_BEEF_5555_AAAA, 40, cap);
        end_frame();
        chk("abort_cr", CR_bus_o, 64'h0123_4567_89AB_CDEF);
        chk("abort_err", {63'd0, frameError_o}, 64'd1);

        frame_body(8'hB1, 64'd0, 8, cap);
        @(negedge clk_i) cs_n_i = 1'b1;
        repeat (SYNC_STAGES) @(posedge clk_i);
        #1;
        chk("enable_oe_early", {63'd0, outputEnable_o}, 64'd0);
        @(posedge clk_i);
        #1;
        chk("enable_oe", {63'd0, outputEnable_o}, 64'd1);
        chk("enable_err", {63'd0, frameError_o}, 64'd0);
        repeat (4) @(posedge clk_i);

        // Shadow holds its old low 32 bits shifted up plus the 32 aborted payload bits.
        frame_body(8'hA3, 64'd0, 8, cap);
        end_frame_commit("commit_partial", 64'h0123_4567_89AB_CDEF, 64'h89AB_CDEF_DEAD_BEEF);

        frame_body(8'h55, 64'd0, 8, cap);
        end_frame();
        chk("unknown_err", {63'd0, frameError_o}, 64'd1);
        chk("unknown_oe", {63'd0, outputEnable_o}, 64'd1);

        frame_body(8'hB0, 64'd0, 8, cap);
        end_frame();
        chk("disable_oe", {63'd0, outputEnable_o}, 64'd0);
        chk("disable_err", {63'd0, frameError_o}, 64'd0);

        frame_body(8'hC0, 64'd0, 72, cap);
        end_frame();
`ifdef FG_CFG_READBACK_EN
        chk("read_data", cap, 64'h89AB_CDEF_DEAD_BEEF);
        chk("read_err", {63'd0, frameError_o}, 64'd0);
`else
        chk("read_miso_zero", cap, 64'd0);
        chk("read_err", {63'd0, frameError_o}, 64'd1);
`endif
        chk("read_miso_idle", {63'd0, miso_o}, 64'd0);
        chk("read_cr", CR_bus_o, 64'h89AB_CDEF_DEAD_BEEF);

        frame_body(8'hB1, 64'd0, 9, cap);
        end_frame();
        chk("extra_edge_err", {63'd0, frameError_o}, 64'd1);
        chk("extra_edge_oe", {63'd0, outputEnable_o}, 64'd0);

        frame_body(8'hA1, 64'h1111_2222_3333_4444, 73, cap);
        end_frame();
        chk("long_err", {63'd0, frameError_o}, 64'd1);
        chk("long_cr", CR_bus_o, 64'h89AB_CDEF_DEAD_BEEF);

        frame_body(8'hA1, 64'hAAAA_5555_AAAA_5555, 30, cap);
        @(negedge clk_i) rstn_i = 1'b0;
        #1;
        chk("midrst_cr", CR_bus_o, 64'd0);
        chk("midrst_oe", {63'd0, outputEnable_o}, 64'd0);
        chk("midrst_err", {63'd0, frameError_o}, 64'd0);
        chk("midrst_upd", {63'd0, configUpdate_o}, 64'd0);
        chk("midrst_miso", {63'd0, miso_o}, 64'd0);
        cs_n_i = 1'b1;
        sclk_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("postrst_err", {63'd0, frameError_o}, 64'd0);

        frame_body(8'hA1, 64'hFFFF_FFFF_FFFF_FFFF, 72, cap);
        end_frame_commit("write_ones", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("write_ones_err", {63'd0, frameError_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
